lp_boxcar_reader: RTL and testbench
===================================

Name: lp_boxcar_reader

Overview:
Reader-side companion to the lock-in low-pass filter chain. It consumes the filtered signal, accumulates 2**dec accepted samples and presents each block average, one word per block, on a valid/ack handshake. The consumer is the register bank or the slow readout logic, which cannot read at the full clock rate. It runs in continuous or one-shot mode and flags overruns when the reader falls behind.

Parameters:
R, 14, input/output sample width (signed); also used with R=28
DMAX, 20, maximum log2 decimation; accumulator width is R+DMAX

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
enable  in  1  block enable; low aborts the current block and returns to IDLE
oneshot  in  1  1 = single block per start pulse, 0 = continuous
start  in  1  one-cycle pulse, starts a block in one-shot mode
dec  in  5  log2 of block length; values above DMAX are clamped to DMAX
in_valid  in  1  input sample strobe (tie high for a per-clock filter output)
in  in  R  signed filtered sample
out_data  out  R  signed block average
out_valid  out  1  average available, held until acked
out_ack  in  1  reader acknowledge
overrun  out  1  sticky; a block completed while out_valid=1 and unacked
busy  out  1  high in the ACCUM state

Behaviour:
- Reset: sets every register asynchronously: state=IDLE, acc=0, cnt=0, out_data=0, out_valid=0, overrun=0, busy=0.
- States:
  - IDLE: enable=1 with oneshot=0 goes to ACCUM. enable=1 with oneshot=1 and start=1 goes to ACCUM.
  - ACCUM: runs the block accumulation described below.
  - DONE: entered in one-shot mode after one block. Waits for start (goes to ACCUM) or enable=0 (goes to IDLE).
- ACCUM block accumulation:
  - dec_l = min(dec, DMAX) is latched on entry to ACCUM and at each block boundary. A dec change mid-block has no effect until the next block.
  - Each cycle with in_valid=1, the first sample of the block loads acc=sign-extended in; later samples do acc=acc+in; cnt increments.
  - When the sample with cnt=2**dec_l-1 is accepted, the block completes.
  - The accumulator cannot overflow: width R+DMAX, at most 2**DMAX samples.
- Block completion:
  - Next cycle: out_data = acc_final >>> dec_l (arithmetic shift, truncation toward -inf), out_valid=1. Latency is 1 clk after the last sample.
  - Continuous mode: the next block begins with the very next in_valid; no samples are dropped.
  - One-shot mode: go to DONE.
- Handshake:
  - out_ack with out_valid=1 clears out_valid next cycle.
  - out_ack while out_valid=0 is ignored.
  - Completion and out_ack in the same cycle: the new word loads, out_valid stays 1, no overrun.
  - Completion while out_valid=1 and no ack: the new word overwrites out_data and overrun is set.
- overrun: cleared only by reset or by the rising edge of enable.
- enable=0 in any state:
  - Next cycle: state=IDLE, acc=0, cnt=0, busy=0.
  - out_data and out_valid are retained, so a pending word is still readable.
  - A partial block is discarded and never output.
- dec=0: every accepted sample is output directly, one cycle later.
- start while in ACCUM: ignored.

Optional Feature:
LP_BOXCAR_ROUND_EN
- Defined: out_data = (acc_final + (dec_l>0 ? 2**(dec_l-1) : 0)) >>> dec_l, i.e. round half up, computed in R+DMAX+1 bits. The result saturates to R-bit max if the rounding add would exceed it.
- Undefined: plain truncation as in Behaviour.

Decomposition:
- Shared lock package:
  - state encoding typedef (IDLE, ACCUM, DONE)
  - localparam DMAX_DEFAULT=20
  - function clamp_dec(dec, DMAX)
- Natural sub-module: lp_boxcar_shift. It is purely the final scaling stage: shift, optional rounding, saturation. It is reusable by other decimators in the chain.
- The state machine, counter and handshake stay in the top module.

Test Plan:
- R=14, dec=2, continuous, in_valid=1, in=100,200,300,400 repeating -> out_data=250 every 4 clks, first at clk 5 after enable; overrun=0 with out_ack the cycle after each out_valid.
- dec=3, in=-1 constant, no ack -> first out_data=-1. The second completion sets overrun=1 and out_data=-1 (overwritten).
- Completion and out_ack in the same cycle -> out_valid stays 1 with the new word, overrun=0.
- oneshot=1, dec=1, start pulse, in=7,8 -> out_data=7 (truncate) or 8 with LP_BOXCAR_ROUND_EN; state=DONE, busy=0, no further words without start.
- enable dropped at cnt=5 of a dec=4 block, then raised -> no output for the partial block; next word is the average of 16 fresh samples; overrun cleared on the rising edge of enable.
- rstn asserted mid-block with out_valid=1 -> all outputs 0 immediately (asynchronous), with no clk edge needed; dec=25 -> behaves as dec=20 (one word per 2**20 samples).

Source files
------------

// File: rtl/lp_boxcar_reader_pkg.sv
// Shared definitions for the lock-in boxcar reader and the scaling stage.
//   state_e         : reader state encoding (IDLE / ACCUM / DONE)
//   DMAX_DEFAULT    : default maximum log2 decimation
//   DEC_W           : width of the decimation control field
//   clamp_dec()     : limits a requested log2 block length to dmax
package lp_boxcar_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DMAX_DEFAULT = 20;
  localparam int DEC_W        = 5;

  // Requested decimations beyond the accumulator headroom collapse to dmax.
  function automatic logic [DEC_W-1:0] clamp_dec(input logic [DEC_W-1:0] dec,
                                                 input int               dmax);
    if (int'(dec) > dmax) begin
      return DEC_W'(dmax);
    end else begin
      return dec;
    end
  endfunction

endpackage

// File: rtl/lp_boxcar_shift.sv
// Final scaling stage for block-average decimators: arithmetic right shift of
// a wide signed accumulator, optional round-half-up, saturation to R bits.
// Purely combinational; the caller registers the result.
//   acc_i   : signed accumulator (R+DMAX bits)
//   shamt_i : shift amount (log2 of the block length, already clamped)
//   data_o  : signed R-bit scaled result
// Build option: define LP_BOXCAR_ROUND_EN for round-half-up; otherwise the
// shift truncates toward minus infinity.
module lp_boxcar_shift
  import lp_boxcar_reader_pkg::*;
#(
  parameter int R    = 14,
  parameter int DMAX = DMAX_DEFAULT
) (
  input  logic signed [R+DMAX-1:0] acc_i,
  input  logic [DEC_W-1:0]         shamt_i,
  output logic signed [R-1:0]      data_o
);

  localparam int AW = R + DMAX;
  // One extra bit so the rounding add can never wrap.
  localparam logic signed [AW:0] SAT_MAX = {{(AW-R+2){1'b0}}, {(R-1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW-R+2){1'b1}}, {(R-1){1'b0}}};
  localparam logic signed [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

  logic signed [AW:0] ext_s;
  logic signed [AW:0] rnd_s;
  logic signed [AW:0] sum_s;
  logic signed [AW:0] shr_s;

  assign ext_s = {acc_i[AW-1], acc_i};

  // Rounding increment: half an output LSB, nothing when no shift applies.
  always_comb begin
    rnd_s = '0;
`ifdef LP_BOXCAR_ROUND_EN
    if (shamt_i != 5'd0) begin
      rnd_s = ONE_W <<< (shamt_i - 5'd1);
    end else begin
      rnd_s = '0;
    end
`endif
  end

  assign sum_s = ext_s + rnd_s;
  assign shr_s = sum_s >>> shamt_i;

  // Clamp to the representable R-bit range (only reachable via rounding).
  always_comb begin
    if (shr_s > SAT_MAX) begin
      data_o = SAT_MAX[R-1:0];
    end else if (shr_s < SAT_MIN) begin
      data_o = SAT_MIN[R-1:0];
    end else begin
      data_o = shr_s[R-1:0];
    end
  end

endmodule

// File: rtl/lp_boxcar_reader.sv
// Reader-side boxcar decimator for the lock-in low-pass chain. Accumulates
// 2**dec accepted samples and presents each block average on a valid/ack
// handshake, in continuous or one-shot mode, with a sticky overrun flag.
//   clk, rstn          : clock, asynchronous active-low reset
//   enable             : low aborts any block and parks the reader in IDLE
//   oneshot, start     : one-shot mode select and its start pulse
//   dec                : log2 block length, clamped to DMAX
//   in_valid, in       : signed sample stream
//   out_data/out_valid : block average, held until out_ack
//   overrun            : sticky, cleared by reset or enable rising edge
//   busy               : high while in ACCUM
// Build option: LP_BOXCAR_ROUND_EN selects round-half-up scaling.
module lp_boxcar_reader
  import lp_boxcar_reader_pkg::*;
#(
  parameter int R    = 14,
  parameter int DMAX = DMAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                oneshot,
  input  logic                start,
  input  logic [DEC_W-1:0]    dec,
  input  logic                in_valid,
  input  logic signed [R-1:0] in,
  output logic signed [R-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ack,
  output logic                overrun,
  output logic                busy
);

  localparam int AW = R + DMAX;
  localparam logic [DMAX-1:0] CNT_ONE = {{(DMAX-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [DMAX-1:0]        cnt_q, cnt_d;
  logic [DEC_W-1:0]       dec_l_q, dec_l_d;
  logic signed [R-1:0]    out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;
  logic                   en_q;

  logic                   accept_s;
  logic                   last_s;
  logic                   en_rise_s;
  logic [DMAX-1:0]        last_cnt_s;
  logic signed [AW-1:0]   in_ext_s;
  logic signed [AW-1:0]   acc_sum_s;
  logic signed [R-1:0]    avg_s;

  // Samples only count while enabled in ACCUM; enable low discards the block.
  assign accept_s   = (state_q == ACCUM) && enable && in_valid;
  // 2**dec_l - 1; wraps correctly to all-ones when dec_l == DMAX.
  assign last_cnt_s = (CNT_ONE << dec_l_q) - CNT_ONE;
  assign last_s     = accept_s && (cnt_q == last_cnt_s);
  assign en_rise_s  = enable && !en_q;
  assign in_ext_s   = {{DMAX{in[R-1]}}, in};
  // First sample of a block loads rather than adds.
  assign acc_sum_s  = (cnt_q == '0) ? in_ext_s : (acc_q + in_ext_s);

  lp_boxcar_shift #(
    .R    (R),
    .DMAX (DMAX)
  ) u_shift (
    .acc_i   (acc_sum_s),
    .shamt_i (dec_l_q),
    .data_o  (avg_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && (!oneshot || start)) begin
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (last_s && oneshot) begin
          state_d = DONE;
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = ACCUM;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath, handshake and flag next-state values.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dec_l_d     = dec_l_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    busy_d      = (state_d == ACCUM);

    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if ((state_q != ACCUM) && (state_d == ACCUM)) begin
      acc_d   = '0;
      cnt_d   = '0;
      dec_l_d = clamp_dec(dec, DMAX);
    end else if (last_s) begin
      // Block boundary: restart the count and pick up any new decimation.
      acc_d   = '0;
      cnt_d   = '0;
      dec_l_d = clamp_dec(dec, DMAX);
    end else if (accept_s) begin
      acc_d = acc_sum_s;
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end

    // A new word wins over an ack arriving in the same cycle.
    if (last_s) begin
      out_data_d  = avg_s;
      out_valid_d = 1'b1;
    end else if (out_ack && out_valid_q) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (en_rise_s) begin
      overrun_d = 1'b0;
    end else if (last_s && out_valid_q && !out_ack) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      dec_l_q     <= 5'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dec_l_q     <= dec_l_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      en_q        <= enable;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lp_boxcar_reader.sv
// Directed testbench for lp_boxcar_reader. DMAX is reduced to 12 so the
// clamped-decimation block (2**DMAX samples) fits in a short run.
module tb_lp_boxcar_reader;

  localparam int R       = 14;
  localparam int DMAX_TB = 12;

  logic                clk = 1'b0;
  logic                rstn;
  logic                enable;
  logic                oneshot;
  logic                start;
  logic [4:0]          dec;
  logic                in_valid;
  logic signed [R-1:0] in_s;
  logic signed [R-1:0] out_data;
  logic                out_valid;
  logic                out_ack;
  logic                overrun;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lp_boxcar_reader #(
    .R    (R),
    .DMAX (DMAX_TB)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .oneshot   (oneshot),
    .start     (start),
    .dec       (dec),
    .in_valid  (in_valid),
    .in        (in_s),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0; enable = 1'b0; oneshot = 1'b0; start = 1'b0; dec = 5'd0;
    in_valid = 1'b0; in_s = '0; out_ack = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; oneshot = 1'b0; start = 1'b0; dec = 5'd0;
    in_valid = 1'b0; in_s = '0; out_ack = 1'b0;
    step();
    step();
    n_checks++; if (out_data !== 14'sd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rstn = 1'b1;
  endtask

  // dec=2, 100/200/300/400 repeating, ack the cycle after each word.
  task automatic test_continuous();
    logic signed [R-1:0] pat [4];
    logic exp_v;
    pat[0] = 14'sd100; pat[1] = 14'sd200; pat[2] = 14'sd300; pat[3] = 14'sd400;
    apply_reset();
    enable = 1'b1; dec = 5'd2; in_valid = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      in_s    = (n >= 2) ? pat[(n-2) % 4] : 14'sd0;
      out_ack = (n == 6) || (n == 10) || (n == 14);
      step();
      exp_v = (n == 5) || (n == 9) || (n == 13) || (n == 17);
      n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL cont_valid clk%0d: got %b expected %b", n, out_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (out_data !== 14'sd250) begin n_fail++; $display("FAIL cont_data clk%0d: got %0d expected 250", n, out_data); end
      end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL cont_overrun clk%0d: got %b expected 0", n, overrun); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy clk%0d: got %b expected 1", n, busy); end
    end
    out_ack = 1'b0;
  endtask

  // dec=3, constant -1, never acked: second word sets overrun.
  task automatic test_overrun();
    apply_reset();
    enable = 1'b1; dec = 5'd3; in_valid = 1'b1; in_s = -14'sd1;
    for (int n = 1; n <= 17; n++) begin
      step();
      if (n == 9) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== -14'sd1) begin n_fail++; $display("FAIL ovr_first_data: got %0d expected -1", out_data); end
      end
      if (n == 16) begin
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b expected 0", overrun); end
      end
    end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    n_checks++; if (out_data !== -14'sd1) begin n_fail++; $display("FAIL ovr_second_data: got %0d expected -1", out_data); end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_clear: got %b expected 0", out_valid); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  // dec=0 pass-through, completion coinciding with ack, stray ack ignored.
  task automatic test_same_cycle_ack();
    apply_reset();
    enable = 1'b1; dec = 5'd0; in_valid = 1'b0;
    step();
    in_valid = 1'b1; in_s = 14'sd11;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 14'sd11) begin n_fail++; $display("FAIL dec0_first: got v=%b d=%0d expected v=1 d=11", out_valid, out_data); end
    in_s = 14'sd22; out_ack = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 14'sd22) begin n_fail++; $display("FAIL same_cycle_word: got v=%b d=%0d expected v=1 d=22", out_valid, out_data); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL same_cycle_overrun: got %b expected 0", overrun); end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear: got %b expected 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stray_ack: got %b expected 0", out_valid); end
    out_ack = 1'b0; in_valid = 1'b1; in_s = -14'sd5;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== -14'sd5 || overrun !== 1'b0) begin n_fail++; $display("FAIL dec0_neg: got v=%b d=%0d o=%b expected v=1 d=-5 o=0", out_valid, out_data, overrun); end
  endtask

  // One-shot dec=1: 7,8 then -3,-4; mid-block dec change has no effect.
  task automatic test_oneshot();
    logic signed [R-1:0] exp1;
    logic signed [R-1:0] exp2;
    logic seen_v;
    logic seen_b;
`ifdef LP_BOXCAR_ROUND_EN
    exp1 = 14'sd8;  exp2 = -14'sd3;
`else
    exp1 = 14'sd7;  exp2 = -14'sd4;
`endif
    apply_reset();
    enable = 1'b1; oneshot = 1'b1; dec = 5'd1; in_valid = 1'b1; in_s = 14'sd7;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL os_wait_start: got busy=%b expected 0", busy); end
    start = 1'b1;
    step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL os_started: got busy=%b expected 1", busy); end
    start = 1'b0; in_s = 14'sd7;
    step();
    in_s = 14'sd8;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== exp1) begin n_fail++; $display("FAIL os_word1: got v=%b d=%0d expected v=1 d=%0d", out_valid, out_data, exp1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL os_done_busy: got %b expected 0", busy); end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0; seen_v = 1'b0; seen_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_s = 14'sd100;
      step();
      if (out_valid) seen_v = 1'b1;
      if (busy) seen_b = 1'b1;
    end
    n_checks++; if (seen_v !== 1'b0 || seen_b !== 1'b0) begin n_fail++; $display("FAIL os_idle_in_done: got v=%b busy=%b expected 0 0", seen_v, seen_b); end
    start = 1'b1;
    step();
    start = 1'b0; dec = 5'd3; in_s = -14'sd3;
    step();
    in_s = -14'sd4;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== exp2) begin n_fail++; $display("FAIL os_word2: got v=%b d=%0d expected v=1 d=%0d", out_valid, out_data, exp2); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL os_done2_busy: got %b expected 0", busy); end
  endtask

  // Abort a dec=4 block after 5 samples; enable rising edge clears overrun.
  task automatic test_abort();
    logic early;
    apply_reset();
    enable = 1'b1; dec = 5'd0; in_valid = 1'b0;
    step();
    in_valid = 1'b1; in_s = 14'sd9;
    step();
    dec = 5'd4;
    step();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL abort_setup_overrun: got %b expected 1", overrun); end
    in_s = 14'sd1000;
    repeat (5) step();
    enable = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 14'sd9) begin n_fail++; $display("FAIL abort_retain: got v=%b d=%0d expected v=1 d=9", out_valid, out_data); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL abort_overrun_kept: got %b expected 1", overrun); end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0; enable = 1'b1;
    step();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL enable_rise_clear: got %b expected 0", overrun); end
    early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_s = R'(i * 10);
      step();
      if (i < 15 && out_valid) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL abort_partial_output: got %b expected 0", early); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 14'sd75) begin n_fail++; $display("FAIL abort_fresh_avg: got v=%b d=%0d expected v=1 d=75", out_valid, out_data); end
  endtask

  // Reset mid-block with a pending word clears outputs without a clock edge.
  task automatic test_async_reset();
    apply_reset();
    enable = 1'b1; dec = 5'd0; in_valid = 1'b1; in_s = 14'sd50;
    step();
    dec = 5'd3;
    step();
    step();
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 14'sd50 || busy !== 1'b1) begin n_fail++; $display("FAIL arst_setup: got v=%b d=%0d b=%b expected v=1 d=50 b=1", out_valid, out_data, busy); end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 14'sd0 || busy !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL arst_immediate: got v=%b d=%0d b=%b o=%b expected all 0", out_valid, out_data, busy, overrun); end
    rstn = 1'b1;
  endtask

  // dec=25 clamps to DMAX_TB=12: one word per 4096 samples.
  task automatic test_dec_clamp();
    logic early;
    apply_reset();
    enable = 1'b1; dec = 5'd25; in_valid = 1'b1; in_s = -14'sd3;
    step();
    early = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      step();
      if (i < 4095 && out_valid) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL clamp_early_word: got %b expected 0", early); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== -14'sd3) begin n_fail++; $display("FAIL clamp_word: got v=%b d=%0d expected v=1 d=-3", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_overrun();
    test_same_cycle_ack();
    test_oneshot();
    test_abort();
    test_async_reset();
    test_dec_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
